// File: rtl/rr_arb_if.sv
// ============================================================================
//  Module      : rr_arb_if
//  Description : Request/grant bundle between requesters and the rr_arb arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arb_if #(
    parameter int N = 5
);
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [2:0]   grant_id;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_id
    );
endinterface

`default_nettype wire

// File: rtl/rr_arb.sv
// ============================================================================
//  Module      : rr_arb
//  Description : Registered 5-way round-robin arbiter with held grants.
//                Define RR_ARB_QUANTUM_EN to compile in the hold quantum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb #(
    parameter int N       = 5,
    parameter int QUANTUM = 4
) (
    input  wire     clk,
    input  wire     rst,
    rr_arb_if.slave bus
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;
    localparam logic [2:0] c_PTR_RST = 3'd4;

    if (N != 5) begin : g_bad_n
        $error("rr_arb supports N == 5 only");
    end
    if (QUANTUM < 1 || QUANTUM > 15) begin : g_bad_quantum
        $error("rr_arb QUANTUM must be in 1..15");
    end

    logic [0:0]   r_state;
    logic [N-1:0] r_grant;
    logic         r_grant_valid;
    logic [2:0]   r_grant_id;
    logic [2:0]   r_ptr;

    logic         w_found;
    logic [2:0]   w_win;
    logic         w_hold_req;
    logic         w_others;
    logic         w_expired;
    logic         w_rearb;

    // Walk downward from ptr, wrapping 0 -> N-1; the first set request wins.
    always_comb begin
        int k;
        w_found = 1'b0;
        w_win   = 3'd0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(r_ptr) - i;
            if (k < 0) begin
                k = k + N;
            end
            if (!w_found && bus.req[k]) begin
                w_found = 1'b1;
                w_win   = 3'(k);
            end
        end
    end

    assign w_hold_req = |(bus.req & r_grant);
    assign w_others   = |(bus.req & ~r_grant);

`ifdef RR_ARB_QUANTUM_EN
    logic [3:0] r_cnt;

    assign w_expired = (r_state == c_HOLD) && (r_cnt == 4'(QUANTUM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_rearb || w_expired) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end
`else
    assign w_expired = 1'b0;
`endif

    // After expiry the holder sits last in the search order, so any other
    // pending requester takes over; a lone holder simply keeps the grant.
    assign w_rearb = (r_state == c_IDLE) || !w_hold_req || (w_expired && w_others);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= 3'd0;
            r_ptr         <= c_PTR_RST;
        end else if (w_rearb) begin
            if (w_found) begin
                r_state       <= c_HOLD;
                r_grant       <= N'(1) << w_win;
                r_grant_valid <= 1'b1;
                r_grant_id    <= w_win;
                r_ptr         <= (w_win == 3'd0) ? 3'(N - 1) : w_win - 3'd1;
            end else begin
                r_state       <= c_IDLE;
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_grant_id    <= 3'd0;
            end
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb.sv
// ============================================================================
//  Module      : tb_rr_arb
//  Description : Self-checking bench for rr_arb: directed plan plus random run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arb;

    localparam int c_QUANTUM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_arb_if #(.N(5)) bus ();

    rr_arb #(.N(5), .QUANTUM(c_QUANTUM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_holder = -1;
    int m_ptr    = 4;
    int m_held   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: holder index (-1 idle), priority pointer, cycles already held.
    function automatic void model_step(input logic r, input logic [4:0] q);
        int  pick;
        bit  quantum_up;
        bit  others;
        if (r) begin
            m_holder = -1;
            m_ptr    = 4;
            m_held   = 0;
            return;
        end
        quantum_up = 1'b0;
`ifdef RR_ARB_QUANTUM_EN
        quantum_up = (m_holder >= 0) && (m_held + 1 >= c_QUANTUM);
`endif
        others = (m_holder >= 0) && ((q & ~(5'(1) << m_holder)) != 5'd0);
        if (m_holder < 0 || !q[m_holder] || (quantum_up && others)) begin
            pick = -1;
            for (int k = 0; k < 5; k++) begin
                if (pick < 0 && q[(m_ptr - k + 5) % 5]) pick = (m_ptr - k + 5) % 5;
            end
            m_holder = pick;
            m_held   = 0;
            if (pick >= 0) m_ptr = (pick + 4) % 5;
        end else if (quantum_up) begin
            m_held = 0;
        end else begin
            m_held++;
        end
    endfunction

    function automatic logic [4:0] exp_grant();
        return (m_holder < 0) ? 5'd0 : (5'(1) << m_holder);
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model_step(rst, bus.req);
        #1;
        check({tag, "_grant"}, 32'(bus.grant), 32'(exp_grant()));
        check({tag, "_valid"}, 32'(bus.grant_valid), 32'(m_holder >= 0));
        check({tag, "_id"}, 32'(bus.grant_id), (m_holder < 0) ? 32'd0 : 32'(m_holder));
    endtask

    logic [4:0] rot_req [5] = '{5'b01111, 5'b10111, 5'b11011, 5'b11101, 5'b11110};
    logic [4:0] rot_exp [5] = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};

    initial begin
        logic [4:0] want;

        // Reset held for two edges with every request high
        bus.req = 5'b11111;
        rst     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick("reset");
            check("reset_lit", 32'(bus.grant), 32'd0);
            check("reset_id_lit", 32'(bus.grant_id), 32'd0);
        end
        rst = 1'b0;
        tick("first");
        check("first_lit", 32'(bus.grant), 32'(5'b10000));
        check("first_id_lit", 32'(bus.grant_id), 32'd4);

        for (int i = 0; i < 5; i++) begin
            bus.req = rot_req[i];
            tick("rot");
            check("rot_lit", 32'(bus.grant), 32'(rot_exp[i]));
        end

        bus.req = 5'b01111;
        tick("walk3");
        check("walk3_lit", 32'(bus.grant), 32'(5'b01000));
        bus.req = 5'b10111;
        tick("walk2");
        check("walk2_lit", 32'(bus.grant), 32'(5'b00100));
        bus.req = 5'b01011;
        tick("b2b");
        check("b2b_lit", 32'(bus.grant), 32'(5'b00010));

        bus.req = 5'b00000;
        tick("idle");
        check("idle_lit", 32'(bus.grant), 32'd0);
        check("idle_valid_lit", 32'(bus.grant_valid), 32'd0);
        bus.req = 5'b00001;
        tick("wake");
        check("wake_lit", 32'(bus.grant), 32'(5'b00001));

        rst = 1'b1;
        tick("qrst");
        rst     = 1'b0;
        bus.req = 5'b10001;
        for (int i = 0; i < 12; i++) begin
            want = 5'b10000;
`ifdef RR_ARB_QUANTUM_EN
            if (i >= 4 && i < 8) want = 5'b00001;
`endif
            tick("quantum");
            check("quantum_lit", 32'(bus.grant), 32'(want));
        end

        rst = 1'b1;
        tick("mrst0");
        rst     = 1'b0;
        bus.req = 5'b01000;
        tick("mhold");
        check("mhold_lit", 32'(bus.grant), 32'(5'b01000));
        bus.req = 5'b01001;
        rst     = 1'b1;
        tick("mrst");
        check("mrst_lit", 32'(bus.grant), 32'd0);
        rst = 1'b0;
        tick("mafter");
        check("mafter_lit", 32'(bus.grant), 32'(5'b01000));

        // Random traffic: requests mostly persist, occasional reset
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 4) bus.req = 5'($urandom_range(0, 31));
            else if ($urandom_range(0, 9) == 0) bus.req = 5'd0;
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
